id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage of the five-stage MIPS core, directly downstream of the opcode decoder. Each cycle it latches the decoder's control bundle, register-file operands, extended immediate and register addresses for the EX stage. It also detects load-use hazards against the instruction in ID, raising a stall for PC and IF/ID while inserting a bubble. It honours branch/jump flushes and an external freeze.

## Interface
- DATA_W, 32, datapath width (PC, operands, immediate)
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-high
- hold_i  in  1  global freeze; all registers keep their value
- flush_i  in  1  branch/jump taken in ID; current ID instruction squashed
- RegDst_i, Jump_i, Branch_i, MemRead_i, MemtoReg_i, ExtOp_i, MemWrite_i, ALUSrc_i, RegWrite_i  in  1 each  decoder control bits
- ALUOp_i  in  2  decoder ALU class
- pc4_i  in  DATA_W  PC+4 of the ID instruction
- rs_data_i, rt_data_i  in  DATA_W  register-file read data
- imm_i  in  16  instruction[15:0]
- rs_i, rt_i, rd_i  in  5 each  register addresses from the ID instruction
- RegDst_o … RegWrite_o, ALUOp_o  out  same widths  registered control bundle to EX
- pc4_o, rs_data_o, rt_data_o, imm_o  out  DATA_W  registered data; imm_o already extended
- rs_o, rt_o, rd_o  out  5 each  registered addresses
- valid_o  out  1  EX slot holds a real instruction (0 = bubble)
- stall_o  out  1  combinational; freeze PC and IF/ID this cycle

## Operation
- Extension, combinational before the register: ExtOp_i=1 gives imm_i sign-extended to DATA_W; ExtOp_i=0 gives zero-extended.
- Hazard (combinational from current outputs and ID inputs): haz = valid_o & MemRead_o & (rt_o != 0) & (rt_o == rs_i | rt_o == rt_i).
- stall_o = haz & ~flush_i & ~hold_i.
- Per-edge update, priority order:
  1. rst_i=1: all outputs 0, valid_o=0.
  2. hold_i=1: every register holds, including valid_o.
  3. flush_i=1 or haz=1: bubble loaded. All control outputs, ALUOp_o, data, addresses and valid_o become 0.
  4. Otherwise: capture all inputs, valid_o=1.
- A bubble is architecturally inert: RegWrite_o=MemWrite_o=MemRead_o=Branch_o=Jump_o=0.
- Decoder bits arrive as-is, including values held over from earlier opcodes for j/beq/sw. The stage applies no masking except in the bubble.
- After a load-use stall, the next edge sees the bubble (valid_o=0), so haz=0. The held ID instruction is then captured. The stall lasts exactly one cycle per load-use pair.
- The stage has no FSM beyond valid_o. State is {valid instruction, bubble}, with transitions as listed above.

## Timing
- Latency: 1 cycle from ID inputs to EX outputs.
- stall_o is valid in the same cycle as the ID inputs and depends on registered state plus rs_i/rt_i. It has no path from data inputs.
- Reset at any point, including a stall cycle, clears everything on that edge. stall_o is 0 in the cycle after reset.
- Simultaneous flush_i and haz: bubble inserted, stall_o=0 (the squashed instruction need not be held).
- Simultaneous hold_i with anything: hold wins. stall_o=0 and no bubble is inserted.
- rt_o=0 (load to $zero) never stalls.

## Test plan
- Reset: hold rst_i 2 cycles with random inputs, then check all outputs 0, valid_o=0, stall_o=0. Release, apply addi (RegWrite_i=1, ExtOp_i=1, imm_i=16'hFFFF), then check imm_o=32'hFFFFFFFF, RegWrite_o=1, valid_o=1 next cycle.
- Zero-extend: ori with ExtOp_i=0, imm_i=16'h8001, then check imm_o=32'h00008001, ALUOp_o=2'b10.
- Load-use: lw rt=5 latched, then ID presents rs_i=5. Check stall_o=1 that cycle. The next edge gives valid_o=0 with all control 0. With the same ID inputs the following edge captures them and stall_o=0. Repeat with rt_i=5, and with lw rt=0 (no stall).
- Flush: flush_i=1 with a valid sw in ID. Check MemWrite_o=0, valid_o=0 next cycle. flush_i with haz asserted: stall_o=0, bubble.
- Hold: latch lw rt=7, then assert hold_i 3 cycles while ID presents rs_i=7 and flush_i=1. Check outputs unchanged and stall_o=0 throughout. Release, then check stall_o=1 and bubble next edge.
- Reset mid-stall: assert rst_i during a stall cycle. Check all outputs 0 next edge and stall_o=0.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: decoder controls, operands and addresses going in,
// the registered EX-side copy plus stall/valid coming out.
interface id_ex_stage_if #(
    parameter int DATA_W = 32
);
    logic              hold_i;
    logic              flush_i;

    logic              RegDst_i;
    logic              Jump_i;
    logic              Branch_i;
    logic              MemRead_i;
    logic              MemtoReg_i;
    logic              ExtOp_i;
    logic              MemWrite_i;
    logic              ALUSrc_i;
    logic              RegWrite_i;
    logic [1:0]        ALUOp_i;

    logic [DATA_W-1:0] pc4_i;
    logic [DATA_W-1:0] rs_data_i;
    logic [DATA_W-1:0] rt_data_i;
    logic [15:0]       imm_i;
    logic [4:0]        rs_i;
    logic [4:0]        rt_i;
    logic [4:0]        rd_i;

    logic              RegDst_o;
    logic              Jump_o;
    logic              Branch_o;
    logic              MemRead_o;
    logic              MemtoReg_o;
    logic              ExtOp_o;
    logic              MemWrite_o;
    logic              ALUSrc_o;
    logic              RegWrite_o;
    logic [1:0]        ALUOp_o;

    logic [DATA_W-1:0] pc4_o;
    logic [DATA_W-1:0] rs_data_o;
    logic [DATA_W-1:0] rt_data_o;
    logic [DATA_W-1:0] imm_o;
    logic [4:0]        rs_o;
    logic [4:0]        rt_o;
    logic [4:0]        rd_o;

    logic              valid_o;
    logic              stall_o;

    // Driven by the ID side / sequencer.
    modport master (
        output hold_i, flush_i,
        output RegDst_i, Jump_i, Branch_i, MemRead_i, MemtoReg_i,
        output ExtOp_i, MemWrite_i, ALUSrc_i, RegWrite_i, ALUOp_i,
        output pc4_i, rs_data_i, rt_data_i, imm_i, rs_i, rt_i, rd_i,
        input  RegDst_o, Jump_o, Branch_o, MemRead_o, MemtoReg_o,
        input  ExtOp_o, MemWrite_o, ALUSrc_o, RegWrite_o, ALUOp_o,
        input  pc4_o, rs_data_o, rt_data_o, imm_o, rs_o, rt_o, rd_o,
        input  valid_o, stall_o
    );

    // Seen by the pipeline register itself.
    modport slave (
        input  hold_i, flush_i,
        input  RegDst_i, Jump_i, Branch_i, MemRead_i, MemtoReg_i,
        input  ExtOp_i, MemWrite_i, ALUSrc_i, RegWrite_i, ALUOp_i,
        input  pc4_i, rs_data_i, rt_data_i, imm_i, rs_i, rt_i, rd_i,
        output RegDst_o, Jump_o, Branch_o, MemRead_o, MemtoReg_o,
        output ExtOp_o, MemWrite_o, ALUSrc_o, RegWrite_o, ALUOp_o,
        output pc4_o, rs_data_o, rt_data_o, imm_o, rs_o, rt_o, rd_o,
        output valid_o, stall_o
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the five-stage MIPS core with immediate
// extension, load-use hazard detection, flush bubbles and global freeze.
module id_ex_stage #(
    parameter int DATA_W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    id_ex_stage_if.slave bus
);
    // The EX slot is the only state: it holds a real instruction or a bubble.
    localparam logic [0:0] ST_BUBBLE = 1'b0;
    localparam logic [0:0] ST_VALID  = 1'b1;

    typedef struct packed {
        logic              valid;
        logic              reg_dst;
        logic              jump;
        logic              branch;
        logic              mem_read;
        logic              mem_to_reg;
        logic              ext_op;
        logic              mem_write;
        logic              alu_src;
        logic              reg_write;
        logic [1:0]        alu_op;
        logic [DATA_W-1:0] pc4;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
    } ex_slot_t;

    ex_slot_t          slot_q;
    ex_slot_t          slot_d;
    ex_slot_t          id_slot;
    logic [DATA_W-1:0] imm_ext;
    logic              haz;

    always_comb begin
        if (bus.ExtOp_i) begin
            imm_ext = {{(DATA_W-16){bus.imm_i[15]}}, bus.imm_i};
        end else begin
            imm_ext = {{(DATA_W-16){1'b0}}, bus.imm_i};
        end
    end

    // Decoder bits pass through untouched; only a bubble clears them.
    always_comb begin
        id_slot            = '0;
        id_slot.valid      = ST_VALID;
        id_slot.reg_dst    = bus.RegDst_i;
        id_slot.jump       = bus.Jump_i;
        id_slot.branch     = bus.Branch_i;
        id_slot.mem_read   = bus.MemRead_i;
        id_slot.mem_to_reg = bus.MemtoReg_i;
        id_slot.ext_op     = bus.ExtOp_i;
        id_slot.mem_write  = bus.MemWrite_i;
        id_slot.alu_src    = bus.ALUSrc_i;
        id_slot.reg_write  = bus.RegWrite_i;
        id_slot.alu_op     = bus.ALUOp_i;
        id_slot.pc4        = bus.pc4_i;
        id_slot.rs_data    = bus.rs_data_i;
        id_slot.rt_data    = bus.rt_data_i;
        id_slot.imm        = imm_ext;
        id_slot.rs         = bus.rs_i;
        id_slot.rt         = bus.rt_i;
        id_slot.rd         = bus.rd_i;
    end

    // A load in EX whose target feeds the ID instruction; $zero never counts.
    assign haz = slot_q.valid & slot_q.mem_read & (slot_q.rt != 5'd0) &
                 ((slot_q.rt == bus.rs_i) | (slot_q.rt == bus.rt_i));

    // stall_o=1 means: PC and IF/ID keep their contents this cycle, so the same
    // ID instruction is re-presented next cycle, when the bubble sits in EX and
    // it is captured. Flush and hold both suppress the stall.
    assign bus.stall_o = haz & ~bus.flush_i & ~bus.hold_i;

    always_comb begin
        slot_d = slot_q;
        if (!bus.hold_i) begin
            if (bus.flush_i || haz) begin
                slot_d       = '0;
                slot_d.valid = ST_BUBBLE;
            end else begin
                slot_d = id_slot;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign bus.valid_o    = slot_q.valid;
    assign bus.RegDst_o   = slot_q.reg_dst;
    assign bus.Jump_o     = slot_q.jump;
    assign bus.Branch_o   = slot_q.branch;
    assign bus.MemRead_o  = slot_q.mem_read;
    assign bus.MemtoReg_o = slot_q.mem_to_reg;
    assign bus.ExtOp_o    = slot_q.ext_op;
    assign bus.MemWrite_o = slot_q.mem_write;
    assign bus.ALUSrc_o   = slot_q.alu_src;
    assign bus.RegWrite_o = slot_q.reg_write;
    assign bus.ALUOp_o    = slot_q.alu_op;
    assign bus.pc4_o      = slot_q.pc4;
    assign bus.rs_data_o  = slot_q.rs_data;
    assign bus.rt_data_o  = slot_q.rt_data;
    assign bus.imm_o      = slot_q.imm;
    assign bus.rs_o       = slot_q.rs;
    assign bus.rt_o       = slot_q.rt;
    assign bus.rd_o       = slot_q.rd;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table for the pipeline corner cases,
// then randomized traffic against a reference model of the EX slot.
module tb_id_ex_stage;
  localparam int W = 32;
  localparam int K_ADDI = 0;
  localparam int K_ORI  = 1;
  localparam int K_LW   = 2;
  localparam int K_SW   = 3;
  localparam int K_R    = 4;

  typedef struct packed {
    logic rst, hold, flush;
    logic regdst, jump, branch, memread, memtoreg, extop, memwrite, alusrc, regwrite;
    logic [1:0] aluop;
    logic [W-1:0] pc4, rs_data, rt_data;
    logic [15:0] imm;
    logic [4:0] rs, rt, rd;
  } in_t;

  typedef struct {
    in_t          in;
    logic         chk_stall;
    logic         exp_stall;
    logic         exp_valid;
    logic [W-1:0] exp_imm;
    logic [2:0]   exp_ctrl;   // {RegWrite, MemWrite, MemRead}
    logic [1:0]   exp_aluop;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  id_ex_stage_if #(.DATA_W(W)) bus ();
  id_ex_stage #(.DATA_W(W)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int n_vec = 0;
  int n_err = 0;
  logic s_stall;
  vec_t tbl[$];

  // reference model: the instruction currently occupying EX
  logic         m_valid = 1'b0;
  in_t          m_slot  = '0;
  logic [W-1:0] m_imm   = '0;

  task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic model_stall(input in_t v);
    logic reads_load;
    reads_load = m_valid && m_slot.memread && m_slot.rt != 5'd0 &&
                 (m_slot.rt == v.rs || m_slot.rt == v.rt);
    return reads_load && !v.flush && !v.hold;
  endfunction

  task automatic model_edge(input in_t v);
    logic reads_load;
    reads_load = m_valid && m_slot.memread && m_slot.rt != 5'd0 &&
                 (m_slot.rt == v.rs || m_slot.rt == v.rt);
    if (v.rst) begin
      m_valid = 1'b0; m_slot = '0; m_imm = '0;
    end else if (v.hold) begin
      // frozen
    end else if (v.flush || reads_load) begin
      m_valid = 1'b0; m_slot = '0; m_imm = '0;
    end else begin
      m_valid = 1'b1;
      m_slot = v;
      m_slot.rst = 1'b0; m_slot.hold = 1'b0; m_slot.flush = 1'b0;
      m_imm = W'(v.imm);
      if (v.extop && v.imm[15]) m_imm = m_imm - 32'h0001_0000;
    end
  endtask

  function automatic logic [159:0] model_out();
    return 160'({m_valid, m_slot.regdst, m_slot.jump, m_slot.branch, m_slot.memread,
                 m_slot.memtoreg, m_slot.extop, m_slot.memwrite, m_slot.alusrc,
                 m_slot.regwrite, m_slot.aluop, m_slot.pc4, m_slot.rs_data,
                 m_slot.rt_data, m_imm, m_slot.rs, m_slot.rt, m_slot.rd});
  endfunction

  function automatic logic [159:0] dut_out();
    return 160'({bus.valid_o, bus.RegDst_o, bus.Jump_o, bus.Branch_o, bus.MemRead_o,
                 bus.MemtoReg_o, bus.ExtOp_o, bus.MemWrite_o, bus.ALUSrc_o,
                 bus.RegWrite_o, bus.ALUOp_o, bus.pc4_o, bus.rs_data_o,
                 bus.rt_data_o, bus.imm_o, bus.rs_o, bus.rt_o, bus.rd_o});
  endfunction

  // driver
  task automatic drive(input in_t v);
    rst            = v.rst;
    bus.hold_i     = v.hold;
    bus.flush_i    = v.flush;
    bus.RegDst_i   = v.regdst;
    bus.Jump_i     = v.jump;
    bus.Branch_i   = v.branch;
    bus.MemRead_i  = v.memread;
    bus.MemtoReg_i = v.memtoreg;
    bus.ExtOp_i    = v.extop;
    bus.MemWrite_i = v.memwrite;
    bus.ALUSrc_i   = v.alusrc;
    bus.RegWrite_i = v.regwrite;
    bus.ALUOp_i    = v.aluop;
    bus.pc4_i      = v.pc4;
    bus.rs_data_i  = v.rs_data;
    bus.rt_data_i  = v.rt_data;
    bus.imm_i      = v.imm;
    bus.rs_i       = v.rs;
    bus.rt_i       = v.rt;
    bus.rd_i       = v.rd;
  endtask

  // one cycle: drive at negedge, check stall, clock, check all outputs
  task automatic step(input in_t v, input logic chk_stall);
    @(negedge clk);
    drive(v);
    #1;
    s_stall = bus.stall_o;
    if (chk_stall) check("stall_model", 160'(s_stall), 160'(model_stall(v)));
    @(posedge clk);
    model_edge(v);
    #1;
    check("outputs_model", dut_out(), model_out());
  endtask

  function automatic in_t rnd_in();
    in_t v;
    v = '0;
    v.hold  = ($urandom_range(0, 9) == 0);
    v.flush = ($urandom_range(0, 9) == 0);
    {v.regdst, v.jump, v.branch, v.memread, v.memtoreg,
     v.extop, v.memwrite, v.alusrc, v.regwrite} = 9'($urandom);
    v.aluop   = 2'($urandom);
    v.pc4     = $urandom;
    v.rs_data = $urandom;
    v.rt_data = $urandom;
    v.imm     = 16'($urandom);
    v.rs      = 5'($urandom_range(0, 7));
    v.rt      = 5'($urandom_range(0, 7));
    v.rd      = 5'($urandom);
    return v;
  endfunction

  function automatic in_t instr(input int kind, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [15:0] imm);
    in_t v;
    v = '0;
    v.pc4 = $urandom; v.rs_data = $urandom; v.rt_data = $urandom; v.rd = 5'($urandom);
    v.rs = rs; v.rt = rt; v.imm = imm;
    case (kind)
      K_ADDI: begin v.regwrite = 1; v.alusrc = 1; v.extop = 1; v.aluop = 2'b00; end
      K_ORI:  begin v.regwrite = 1; v.alusrc = 1; v.extop = 0; v.aluop = 2'b10; end
      K_LW:   begin v.memread = 1; v.memtoreg = 1; v.regwrite = 1; v.alusrc = 1; v.extop = 1; end
      K_SW:   begin v.memwrite = 1; v.alusrc = 1; v.extop = 1; end
      default: begin v.regdst = 1; v.regwrite = 1; v.aluop = 2'b11; end
    endcase
    return v;
  endfunction

  task automatic add(input in_t v, input logic cs, input logic es, input logic ev,
                     input logic [W-1:0] ei, input logic [2:0] ec, input logic [1:0] ea);
    vec_t r;
    r.in = v; r.chk_stall = cs; r.exp_stall = es; r.exp_valid = ev;
    r.exp_imm = ei; r.exp_ctrl = ec; r.exp_aluop = ea;
    tbl.push_back(r);
  endtask

  initial begin
    in_t t;
    drive('0);

    // reset held two cycles with random inputs
    t = rnd_in(); t.rst = 1;                 add(t, 0, 0, 0, 32'h0, 3'b000, 2'b00);
    t = rnd_in(); t.rst = 1;                 add(t, 1, 0, 0, 32'h0, 3'b000, 2'b00);
    // sign- and zero-extension
    add(instr(K_ADDI, 1, 2, 16'hFFFF), 1, 0, 1, 32'hFFFF_FFFF, 3'b100, 2'b00);
    add(instr(K_ORI,  3, 4, 16'h8001), 1, 0, 1, 32'h0000_8001, 3'b100, 2'b10);
    // load-use on rs: one stall, bubble, then capture
    add(instr(K_LW, 1, 5, 16'h0004), 1, 0, 1, 32'h4, 3'b101, 2'b00);
    t = instr(K_ADDI, 5, 6, 16'h0010);
    add(t, 1, 1, 0, 32'h0, 3'b000, 2'b00);
    add(t, 1, 0, 1, 32'h10, 3'b100, 2'b00);
    // load-use on rt
    add(instr(K_LW, 2, 5, 16'h0008), 1, 0, 1, 32'h8, 3'b101, 2'b00);
    t = instr(K_R, 9, 5, 16'h0020);
    add(t, 1, 1, 0, 32'h0, 3'b000, 2'b00);
    add(t, 1, 0, 1, 32'h20, 3'b100, 2'b11);
    // load to $zero never stalls
    add(instr(K_LW, 3, 0, 16'h0000), 1, 0, 1, 32'h0, 3'b101, 2'b00);
    add(instr(K_ADDI, 0, 0, 16'h0001), 1, 0, 1, 32'h1, 3'b100, 2'b00);
    // flush squashes a store
    t = instr(K_SW, 4, 6, 16'hFFF0); t.flush = 1;
    add(t, 1, 0, 0, 32'h0, 3'b000, 2'b00);
    // flush together with a hazard: no stall, bubble
    add(instr(K_LW, 1, 8, 16'h000C), 1, 0, 1, 32'hC, 3'b101, 2'b00);
    t = instr(K_ADDI, 8, 1, 16'h0002); t.flush = 1;
    add(t, 1, 0, 0, 32'h0, 3'b000, 2'b00);
    // hold over a pending hazard and flush: everything frozen
    add(instr(K_LW, 2, 7, 16'h0100), 1, 0, 1, 32'h100, 3'b101, 2'b00);
    t = instr(K_ADDI, 7, 3, 16'h0005); t.hold = 1; t.flush = 1;
    for (int i = 0; i < 3; i++) add(t, 1, 0, 1, 32'h100, 3'b101, 2'b00);
    t.hold = 0; t.flush = 0;
    add(t, 1, 1, 0, 32'h0, 3'b000, 2'b00);
    add(t, 1, 0, 1, 32'h5, 3'b100, 2'b00);
    // reset during a stall cycle
    add(instr(K_LW, 1, 9, 16'h0008), 1, 0, 1, 32'h8, 3'b101, 2'b00);
    t = instr(K_ADDI, 9, 2, 16'h0003); t.rst = 1;
    add(t, 1, 1, 0, 32'h0, 3'b000, 2'b00);
    t.rst = 0;
    add(t, 1, 0, 1, 32'h3, 3'b100, 2'b00);

    foreach (tbl[i]) begin
      step(tbl[i].in, tbl[i].chk_stall);
      if (tbl[i].chk_stall) check($sformatf("stall[%0d]", i), 160'(s_stall), 160'(tbl[i].exp_stall));
      check($sformatf("valid[%0d]", i), 160'(bus.valid_o), 160'(tbl[i].exp_valid));
      check($sformatf("imm[%0d]", i), 160'(bus.imm_o), 160'(tbl[i].exp_imm));
      check($sformatf("ctrl[%0d]", i), 160'({bus.RegWrite_o, bus.MemWrite_o, bus.MemRead_o}),
            160'(tbl[i].exp_ctrl));
      check($sformatf("aluop[%0d]", i), 160'(bus.ALUOp_o), 160'(tbl[i].exp_aluop));
    end

    // randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      t = rnd_in();
      t.rst = ($urandom_range(0, 49) == 0);
      step(t, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
